mc_control_fsm: RTL

Main controller for the multi-cycle RV32I core. It sequences the shared datapath one instruction at a time: PC, instruction register, single memory port, ALU source muxes, result mux and the register file write enable. It is a Moore state machine plus an ALU decoder and an immediate-select decoder. `pcwrite` is the only output that also depends on a datapath input (`zero`).

---
 rtl/mc_control_fsm.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Main controller for the multi-cycle RV32I core: a Moore sequencer with an ALU decoder
// and an immediate-format decoder. pcwrite alone also looks at the datapath zero flag.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] immsrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state_q, state_d;
  logic       pcupdate, branch;
  logic       irwrite_raw, regwrite_raw, memwrite_raw;
  logic [1:0] aluop;

  // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every signal written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = S_FETCH;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: regwrite_raw = 1'b1;
      // The jump target was already computed into ALUOut during DECODE.
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Architectural writes are masked during reset so a half-finished instruction commits nothing.
  assign pcwrite  = ~reset & (pcupdate | (branch & zero));
  assign irwrite  = ~reset & irwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign state    = state_q;

endmodule
